// File: rtl/demux_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : demux_channel_scheduler
// Purpose : Round-robin sequencer driving DeMux_1to8 in/sel with a dwell hold.
// Revision: 1.0
// ============================================================================
module demux_channel_scheduler #(
    parameter int NCH     = 8,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NCH-1:0]     ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               dm_in,
    output logic [SEL_W-1:0]   dm_sel,
    output logic               dm_active,
    output logic [7:0]         grant_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic               dm_in_q;
    logic [SEL_W-1:0]   dm_sel_q;
    logic               dm_active_q;
    logic [7:0]         grant_cnt_q;
    logic [SEL_W-1:0]   last_sel_q;
    logic [DWELL_W-1:0] cnt_q;

    logic [SEL_W-1:0]   nxt_sel_d;
    logic [DWELL_W-1:0] cnt_load_d;

    // Search starts just past the last grant; last_sel itself comes last so a
    // lone enabled channel is re-granted.
    always_comb begin : p_rr_search
        logic             found;
        logic [SEL_W-1:0] idx;
        nxt_sel_d = last_sel_q;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = last_sel_q + SEL_W'(i);
            if (!found && ch_mask[idx]) begin
                nxt_sel_d = idx;
                found     = 1'b1;
            end
        end
    end

    assign cnt_load_d = (dwell == '0) ? '0 : dwell - 1'b1;
    assign in_ready   = (state_q == S_IDLE) && (ch_mask != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dm_in_q     <= 1'b0;
            dm_sel_q    <= '0;
            dm_active_q <= 1'b0;
            grant_cnt_q <= 8'd0;
            last_sel_q  <= SEL_W'(NCH - 1);
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        dm_sel_q    <= nxt_sel_d;
                        last_sel_q  <= nxt_sel_d;
                        dm_in_q     <= in_data;
                        dm_active_q <= 1'b1;
                        cnt_q       <= cnt_load_d;
                        grant_cnt_q <= grant_cnt_q + 8'd1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // dm_sel is left alone so the lane only ever changes while dm_in is 0
                        state_q     <= S_IDLE;
                        dm_active_q <= 1'b0;
                        dm_in_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign dm_in     = dm_in_q;
    assign dm_sel    = dm_sel_q;
    assign dm_active = dm_active_q;
    assign grant_cnt = grant_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux_channel_scheduler
// Purpose : Directed + random checks of demux_channel_scheduler against a model.
// Revision: 1.0
// ============================================================================
module tb_demux_channel_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_data = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] ch_mask = 8'h00;
    logic [3:0] dwell = 4'd0;
    logic       dm_in;
    logic [2:0] dm_sel;
    logic       dm_active;
    logic [7:0] grant_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: hold cycles left, last granted lane, visible outputs.
    int m_hold  = 0;
    int m_last  = 7;
    int m_sel   = 0;
    int m_in    = 0;
    int m_grant = 0;

    demux_channel_scheduler #(.NCH(8), .SEL_W(3), .DWELL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .dm_in     (dm_in),
        .dm_sel    (dm_sel),
        .dm_active (dm_active),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_hold == 0) && (ch_mask != 8'h00);
    endfunction

    task automatic model_reset();
        m_hold = 0; m_last = 7; m_sel = 0; m_in = 0; m_grant = 0;
    endtask

    task automatic model_step();
        int nxt;
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_in = 0;
        end else if (in_valid && m_ready()) begin
            nxt = -1;
            for (int k = 1; k <= 8; k++)
                if (nxt < 0 && ch_mask[(m_last + k) % 8]) nxt = (m_last + k) % 8;
            m_sel   = nxt;
            m_last  = nxt;
            m_in    = int'(in_data);
            m_hold  = (dwell == 4'd0) ? 1 : int'(dwell);
            m_grant = (m_grant + 1) % 256;
        end
    endtask

    // Called just after a negedge with inputs already set for the coming edge.
    task automatic cycle();
        #1;
        chk("in_ready",  32'(in_ready),  32'(m_ready()));
        chk("dm_active", 32'(dm_active), 32'(m_hold > 0));
        chk("dm_in",     32'(dm_in),     32'(m_in));
        chk("dm_sel",    32'(dm_sel),    32'(m_sel));
        chk("grant_cnt", 32'(grant_cnt), 32'(m_grant));
        model_step();
        @(negedge clk);
    endtask

    task automatic send_word(input logic d);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 40 && !done; t++) begin
            acc = m_ready();
            cycle();
            if (acc) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && m_hold > 0; t++) cycle();
    endtask

    task automatic active_len(input string tag, input int exp);
        int n;
        n = 0;
        for (int t = 0; t < 40 && dm_active; t++) begin
            n++;
            cycle();
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    int exp2[4] = '{2, 5, 7, 2};

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dm_in",     32'(dm_in),     32'd0);
        chk("rst_dm_sel",    32'(dm_sel),    32'd0);
        chk("rst_dm_active", 32'(dm_active), 32'd0);
        chk("rst_grant",     32'(grant_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Full mask, dwell 2: lanes visited in order
        ch_mask = 8'hFF; dwell = 4'd2;
        for (int i = 0; i < 8; i++) begin
            send_word(1'b1);
            chk("t1_sel", 32'(dm_sel), 32'(i));
            chk("t1_in",  32'(dm_in),  32'd1);
            active_len("t1_len", 2);
        end
        chk("t1_grant", 32'(grant_cnt), 32'd8);

        // Sparse mask, dwell 1
        ch_mask = 8'b1010_0100; dwell = 4'd1;
        for (int i = 0; i < 4; i++) begin
            send_word(1'(i & 1));
            chk("t2_sel", 32'(dm_sel), 32'(exp2[i]));
            drain();
        end

        // Dwell boundaries
        ch_mask = 8'hFF; dwell = 4'd0;
        send_word(1'b1);
        active_len("dwell0_len", 1);
        dwell = 4'd15;
        send_word(1'b1);
        active_len("dwell15_len", 15);
        cycle();

        // Empty mask blocks acceptance, then single-lane re-grant
        ch_mask = 8'h00; in_valid = 1'b1; in_data = 1'b1; dwell = 4'd1;
        for (int i = 0; i < 5; i++) cycle();
        chk("mask0_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        ch_mask = 8'h10;
        send_word(1'b1);
        chk("single_sel_a", 32'(dm_sel), 32'd4);
        drain();
        send_word(1'b0);
        chk("single_sel_b", 32'(dm_sel), 32'd4);
        drain();

        // Mask/dwell changes mid-hold do not affect current word
        ch_mask = 8'hFF; dwell = 4'd6;
        send_word(1'b1);
        chk("mid_sel", 32'(dm_sel), 32'd5);
        ch_mask = 8'h01; dwell = 4'd2;
        active_len("mid_len", 6);
        send_word(1'b1);
        chk("mid_next_sel", 32'(dm_sel), 32'd0);
        active_len("mid_next_len", 2);

        // Async reset mid-hold
        ch_mask = 8'h10; dwell = 4'd8;
        send_word(1'b1);
        cycle(); cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_dm_in",     32'(dm_in),     32'd0);
        chk("arst_dm_sel",    32'(dm_sel),    32'd0);
        chk("arst_dm_active", 32'(dm_active), 32'd0);
        chk("arst_grant",     32'(grant_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ch_mask = 8'h24; dwell = 4'd1;
        send_word(1'b1);
        chk("arst_first_sel", 32'(dm_sel), 32'd2);
        drain();

        // Random traffic with mask/dwell changing at any time
        for (int i = 0; i < 500; i++) begin
            ch_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            dwell    = 4'($urandom);
            in_valid = 1'($urandom);
            in_data  = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
